// File: rtl/sequence_detector_101_pkg.sv
// Shared types for the serial 1-0-1 pattern detector.
// State encoding is fixed so the output decode stays a single compare.
package sequence_detector_101_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE = 2'd0,
        S_1    = 2'd1,
        S_10   = 2'd2,
        S_101  = 2'd3
    } state_t;

endpackage

// File: rtl/sequence_detector_101.sv
// Moore detector for the serial pattern 1-0-1 (oldest bit first).
// The flag is registered, so in_seq has no combinational path to out_seq.
module sequence_detector_101
    import sequence_detector_101_pkg::*;
#(
    parameter bit OVERLAP = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic in_seq,
    output logic out_seq
);

    state_t state;
    state_t state_nxt;
    logic   out_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= S_IDLE;
            out_q <= 1'b0;
        end else begin
            state <= state_nxt;
            out_q <= (state_nxt == S_101);
        end
    end

    always_comb begin
        state_nxt = S_IDLE;
        unique case (state)
            S_IDLE: state_nxt = in_seq ? S_1 : S_IDLE;
            S_1:    state_nxt = in_seq ? S_1 : S_10;
            S_10:   state_nxt = in_seq ? S_101 : S_IDLE;
            // Without overlap the trailing 1 is consumed by the match.
            S_101: begin
                if (in_seq)
                    state_nxt = S_1;
                else if (OVERLAP)
                    state_nxt = S_10;
                else
                    state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign out_seq = out_q;

endmodule

// File: tb/tb_sequence_detector_101.sv
// Scoreboard bench for both OVERLAP settings driven with the same stream.
module tb_sequence_detector_101;

    logic clk = 1'b0;
    logic reset;
    logic in_seq;
    logic out_ov;
    logic out_no;

    always #600 clk = ~clk;

    sequence_detector_101 #(.OVERLAP(1'b1)) dut_ov (
        .clk    (clk),
        .reset  (reset),
        .in_seq (in_seq),
        .out_seq(out_ov)
    );

    sequence_detector_101 #(.OVERLAP(1'b0)) dut_no (
        .clk    (clk),
        .reset  (reset),
        .in_seq (in_seq),
        .out_seq(out_no)
    );

    typedef struct {
        int   cyc;
        logic e_ov;
        logic e_no;
        string tag;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_err = 0;
    int   pulses_ov = 0;
    int   pulses_no = 0;

    logic [2:0] hist;
    int         nbit;
    int         last_no;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t e;
            e = q.pop_front();
            chk({e.tag, "/ov"}, {31'd0, out_ov}, {31'd0, e.e_ov});
            chk({e.tag, "/no"}, {31'd0, out_no}, {31'd0, e.e_no});
            if (out_ov === 1'b1) pulses_ov++;
            if (out_no === 1'b1) pulses_no++;
        end
    end

    // Reference: pattern match on bit history since the last reset.
    task automatic drive(input string tag, input logic r, input logic b);
        exp_t e;
        logic m;
        @(posedge clk);
        #50;
        reset  = r;
        in_seq = b;
        if (!r) begin
            hist    = 3'b000;
            nbit    = 0;
            last_no = 0;
            e.e_ov  = 1'b0;
            e.e_no  = 1'b0;
        end else begin
            hist   = {hist[1:0], b};
            nbit++;
            m      = (nbit >= 3) && (hist == 3'b101);
            e.e_ov = m;
            e.e_no = m && (nbit - 2 > last_no);
            if (e.e_no) last_no = nbit;
        end
        e.cyc = cyc + 1;
        e.tag = tag;
        q.push_back(e);
    endtask

    logic [15:0] stream;

    initial begin
        reset  = 1'b1;
        in_seq = 1'b0;
        hist    = 3'b000;
        nbit    = 0;
        last_no = 0;
        stream  = 16'b0010100110101011;

        drive("rst_x", 1'b0, 1'bx);

        for (int i = 0; i < 16; i++)
            drive("stream", 1'b1, stream[i]);
        drive("flush", 1'b1, 1'b0);

        drive("pre1", 1'b1, 1'b1);
        drive("pre0", 1'b1, 1'b0);
        drive("mid_rst", 1'b0, 1'b0);
        drive("post1", 1'b1, 1'b1);

        for (int i = 0; i < 16; i++)
            drive("zeros", 1'b1, 1'b0);
        for (int i = 0; i < 16; i++)
            drive("ones", 1'b1, 1'b1);

        drive("r6_1", 1'b1, 1'b1);
        drive("r6_0", 1'b1, 1'b0);
        drive("r6_rst", 1'b0, 1'b1);
        drive("r6_after", 1'b1, 1'b0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("drain", q.size(), 32'd0);
        chk("pulses_ov", pulses_ov, 32'd4);
        chk("pulses_no", pulses_no, 32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_err);
        $finish;
    end

endmodule
